// File: rtl/spike_enc_pkg.sv
// Shared widths, event type and stage-2 decision encoding for the spike event encoder.
package spike_enc_pkg;

    localparam int NEURON_COUNT = 500;
    localparam int DATA_WIDTH   = 16;
    localparam int STEP_WIDTH   = 16;
    localparam int FIFO_DEPTH   = 16;

    localparam int ID_W    = $clog2(NEURON_COUNT);
    localparam int EVENT_W = ID_W + STEP_WIDTH;

    // Q4.12 unity: 4096 represents a membrane value of 1.0
    localparam logic signed [DATA_WIDTH-1:0] ONE_Q = 16'sd4096;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [STEP_WIDTH-1:0] step;
    } spike_event_t;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_FIRE  = 2'd1,
        ACT_REARM = 2'd2
    } neuron_action_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle, otherwise it is reported on o_drop.
module spike_event_fifo
    import spike_enc_pkg::*;
#(
    parameter int WIDTH = EVENT_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_drop    = i_push && !w_do_push;
    assign o_valid   = !w_empty;
    assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/spike_event_encoder.sv
// Spike event encoder: per-neuron threshold crossing with hysteresis, events queued in a FWFT FIFO.
// Define SPIKE_ENC_RATE_EN to add rate_count, the number of fires seen in the last completed step.
module spike_event_encoder #(
    parameter int NEURON_COUNT = spike_enc_pkg::NEURON_COUNT,
    parameter int DATA_WIDTH   = spike_enc_pkg::DATA_WIDTH,
    parameter int STEP_WIDTH   = spike_enc_pkg::STEP_WIDTH,
    parameter int FIFO_DEPTH   = spike_enc_pkg::FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [$clog2(NEURON_COUNT)-1:0] in_id,
    input  logic signed [DATA_WIDTH-1:0]    in_v,
    input  logic signed [DATA_WIDTH-1:0]    thr_hi,
    input  logic signed [DATA_WIDTH-1:0]    thr_lo,
    output logic                            ev_valid,
    input  logic                            ev_ready,
    output logic [$clog2(NEURON_COUNT)-1:0] ev_id,
    output logic [STEP_WIDTH-1:0]           ev_step,
    output logic [STEP_WIDTH-1:0]           step_count,
    output logic [15:0]                     drop_count
`ifdef SPIKE_ENC_RATE_EN
    ,
    output logic [$clog2(NEURON_COUNT+1)-1:0] rate_count
`endif
);

    import spike_enc_pkg::*;

    localparam int IDW = $clog2(NEURON_COUNT);
    localparam int EVW = IDW + STEP_WIDTH;
    localparam logic [IDW-1:0] LAST_ID = IDW'(NEURON_COUNT - 1);

    logic                         r_s1_valid;
    logic [IDW-1:0]               r_s1_id;
    logic signed [DATA_WIDTH-1:0] r_s1_v;
    logic [NEURON_COUNT-1:0]      r_armed;
    logic [STEP_WIDTH-1:0]        r_step_count;
    logic                         r_s2_fire;
    logic [EVW-1:0]               r_s2_event;
    logic [15:0]                  r_drop_count;

    neuron_action_t w_action;
    logic           w_armed_cur;
    logic           w_step_end;
    logic           w_pop;
    logic           w_drop;
    logic [EVW-1:0] w_head;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) r_s1_valid <= 1'b0;
        else      r_s1_valid <= in_valid && (in_id <= LAST_ID);
    end

    // NOTE: payload flops qualified by a valid bit carry no reset; only control state does.
    always_ff @(posedge clk) begin
        r_s1_id <= in_id;
        r_s1_v  <= in_v;
    end

    assign w_armed_cur = r_armed[r_s1_id];
    assign w_step_end  = r_s1_valid && (r_s1_id == LAST_ID);

    // NOTE: default assigned first so no path leaves w_action unassigned (no latch).
    always_comb begin
        w_action = ACT_HOLD;
        if (r_s1_valid) begin
            if (w_armed_cur && (r_s1_v >= thr_hi))
                w_action = ACT_FIRE;
            else if (!w_armed_cur && (r_s1_v < thr_lo))
                w_action = ACT_REARM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_armed      <= '1;
            r_step_count <= '0;
            r_s2_fire    <= 1'b0;
        end else begin
            case (w_action)
                ACT_FIRE:  r_armed[r_s1_id] <= 1'b0;
                ACT_REARM: r_armed[r_s1_id] <= 1'b1;
                default:   ;
            endcase
            if (w_step_end) r_step_count <= r_step_count + 1'b1;
            r_s2_fire <= (w_action == ACT_FIRE);
        end
    end

    // The event is stamped with the step count before this sample's own increment lands
    always_ff @(posedge clk) begin
        r_s2_event <= {r_s1_id, r_step_count};
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_drop_count <= '0;
        else if (w_drop && (r_drop_count != 16'hFFFF))
            r_drop_count <= r_drop_count + 1'b1;
    end

    assign w_pop = ev_valid && ev_ready;

    spike_event_fifo #(
        .WIDTH (EVW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s2_fire),
        .i_data  (r_s2_event),
        .i_pop   (w_pop),
        .o_valid (ev_valid),
        .o_data  (w_head),
        .o_drop  (w_drop)
    );

    assign {ev_id, ev_step} = w_head;
    assign step_count       = r_step_count;
    assign drop_count       = r_drop_count;

`ifdef SPIKE_ENC_RATE_EN
    localparam int RATE_W = $clog2(NEURON_COUNT + 1);

    logic [RATE_W-1:0] r_fire_cnt;
    logic [RATE_W-1:0] r_rate_count;
    logic              w_fire;

    assign w_fire = (w_action == ACT_FIRE);

    // A fire from the last slot belongs to the step it closes
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fire_cnt   <= '0;
            r_rate_count <= '0;
        end else if (w_step_end) begin
            r_rate_count <= r_fire_cnt + RATE_W'(w_fire);
            r_fire_cnt   <= '0;
        end else if (w_fire) begin
            r_fire_cnt <= r_fire_cnt + 1'b1;
        end
    end

    assign rate_count = r_rate_count;
`endif

endmodule

// File: tb/tb_spike_event_encoder.sv
// Self-checking bench for spike_event_encoder: sample-level reference model, directed scenarios,
// randomized traffic, plus a narrow-step instance for counter wrap.
module tb_spike_event_encoder;
    import spike_enc_pkg::*;

    localparam int N     = NEURON_COUNT;
    localparam int DEPTH = FIFO_DEPTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst;
    logic                         in_valid;
    logic [ID_W-1:0]              in_id;
    logic signed [DATA_WIDTH-1:0] in_v;
    logic signed [DATA_WIDTH-1:0] thr_hi;
    logic signed [DATA_WIDTH-1:0] thr_lo;
    logic                         ev_valid;
    logic                         ev_ready;
    logic [ID_W-1:0]              ev_id;
    logic [STEP_WIDTH-1:0]        ev_step;
    logic [STEP_WIDTH-1:0]        step_count;
    logic [15:0]                  drop_count;
`ifdef SPIKE_ENC_RATE_EN
    logic [$clog2(N+1)-1:0]       rate_count;
`endif

    spike_event_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_id      (in_id),
        .in_v       (in_v),
        .thr_hi     (thr_hi),
        .thr_lo     (thr_lo),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_id      (ev_id),
        .ev_step    (ev_step),
        .step_count (step_count),
        .drop_count (drop_count)
`ifdef SPIKE_ENC_RATE_EN
        ,
        .rate_count (rate_count)
`endif
    );

    // Narrow instance: 5 neurons, 4-bit step counter
    logic              s_valid;
    logic [2:0]        s_id;
    logic signed [15:0] s_v;
    logic              s_ready;
    logic              s_ev_valid;
    logic [2:0]        s_ev_id;
    logic [3:0]        s_ev_step;
    logic [3:0]        s_step;
    logic [15:0]       s_drop;
`ifdef SPIKE_ENC_RATE_EN
    logic [2:0]        s_rate;
`endif

    spike_event_encoder #(
        .NEURON_COUNT (5),
        .DATA_WIDTH   (16),
        .STEP_WIDTH   (4),
        .FIFO_DEPTH   (4)
    ) dut_small (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s_valid),
        .in_id      (s_id),
        .in_v       (s_v),
        .thr_hi     (thr_hi),
        .thr_lo     (thr_lo),
        .ev_valid   (s_ev_valid),
        .ev_ready   (s_ready),
        .ev_id      (s_ev_id),
        .ev_step    (s_ev_step),
        .step_count (s_step),
        .drop_count (s_drop)
`ifdef SPIKE_ENC_RATE_EN
        ,
        .rate_count (s_rate)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (sample-level, latency applied as delays) -------------
    spike_event_t    exp_q[$];
    bit              armed[N];
    logic [15:0]     m_step;
    logic [15:0]     exp_step_out;
    logic [15:0]     exp_drop;
    bit              dly_v[2];
    spike_event_t    dly_e[2];
    int              m_fire_cnt;
    int              m_rate;
    int              exp_rate_out;
    bit              model_ready = 1'b0;

    always @(posedge clk) begin
        bit popped;
        bit full;
        bit fire;
        spike_event_t ev;
        if (!rst) begin
            exp_q.delete();
            foreach (armed[i]) armed[i] = 1'b1;
            m_step       = '0;
            exp_step_out = '0;
            exp_drop     = '0;
            dly_v[0]     = 1'b0;
            dly_v[1]     = 1'b0;
            m_fire_cnt   = 0;
            m_rate       = 0;
            exp_rate_out = 0;
            model_ready  = 1'b1;
        end else if (model_ready) begin
            popped = (exp_q.size() > 0) && ev_ready;
            full   = (exp_q.size() == DEPTH);
            if (popped) void'(exp_q.pop_front());
            if (dly_v[1]) begin
                if (!full || popped) exp_q.push_back(dly_e[1]);
                else if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
            end
            dly_v[1] = dly_v[0];
            dly_e[1] = dly_e[0];
            dly_v[0] = 1'b0;
            exp_step_out = m_step;
            exp_rate_out = m_rate;
            if (in_valid && (int'(in_id) < N)) begin
                fire = armed[in_id] && (in_v >= thr_hi);
                if (fire) begin
                    armed[in_id] = 1'b0;
                    ev.id    = in_id;
                    ev.step  = m_step;
                    dly_v[0] = 1'b1;
                    dly_e[0] = ev;
                    m_fire_cnt++;
                end else if (!armed[in_id] && (in_v < thr_lo)) begin
                    armed[in_id] = 1'b1;
                end
                if (int'(in_id) == N - 1) begin
                    m_step     = m_step + 16'd1;
                    m_rate     = m_fire_cnt;
                    m_fire_cnt = 0;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (model_ready) begin
            check("ev_valid", 64'(ev_valid), 64'(exp_q.size() > 0));
            check("ev_id",   64'(ev_id),   (exp_q.size() > 0) ? 64'(exp_q[0].id)   : 64'(0));
            check("ev_step", 64'(ev_step), (exp_q.size() > 0) ? 64'(exp_q[0].step) : 64'(0));
            check("step_count", 64'(step_count), 64'(exp_step_out));
            check("drop_count", 64'(drop_count), 64'(exp_drop));
`ifdef SPIKE_ENC_RATE_EN
            check("rate_count", 64'(rate_count), 64'(exp_rate_out));
`endif
        end
    end

    // Accepted-event log for literal order checks
    spike_event_t acc_log[$];
    always @(negedge clk) begin
        if (rst && ev_valid && ev_ready) acc_log.push_back(spike_event_t'({ev_id, ev_step}));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int id, input int v);
        in_valid = 1'b1;
        in_id    = ID_W'(id);
        in_v     = 16'(v);
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic sweep(input int hot_id, input int hot_v, input int other_v);
        for (int i = 0; i < N; i++) put(i, (i == hot_id) ? hot_v : other_v);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_id    = '0;
        in_v     = '0;
        thr_hi   = ONE_Q;
        thr_lo   = 16'sd0;
        ev_ready = 1'b0;
        s_valid  = 1'b0;
        s_id     = '0;
        s_v      = '0;
        s_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_ev_valid", 64'(ev_valid), 64'(0));
        check("rst_ev_id", 64'(ev_id), 64'(0));
        check("rst_ev_step", 64'(ev_step), 64'(0));
        check("rst_step_count", 64'(step_count), 64'(0));
        check("rst_drop_count", 64'(drop_count), 64'(0));
        rst = 1'b1;

        // Narrow instance: 4-bit step counter wraps 15 -> 0
        s_valid = 1'b1;
        s_id    = 3'd4;
        s_v     = 16'sd0;
        repeat (15) tick();
        s_valid = 1'b0;
        tick();
        check("wrap_step_15", 64'(s_step), 64'(15));
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        check("wrap_step_0", 64'(s_step), 64'(0));
        check("small_ev_valid", 64'(s_ev_valid), 64'(0));
        check("small_ev_id", 64'({s_ev_id, s_ev_step}), 64'(0));
        check("small_drop", 64'(s_drop), 64'(0));
`ifdef SPIKE_ENC_RATE_EN
        check("small_rate", 64'(s_rate), 64'(0));
`endif

        // 1: single fire, latency T+3
        put(7, 5000);
        check("t1_valid_T1", 64'(ev_valid), 64'(0));
        idle(1);
        check("t1_valid_T2", 64'(ev_valid), 64'(0));
        idle(1);
        check("t1_valid_T3", 64'(ev_valid), 64'(1));
        check("t1_ev", 64'({ev_id, ev_step}), 64'({9'd7, 16'd0}));
        ev_ready = 1'b1;
        idle(1);
        check("t1_popped", 64'(ev_valid), 64'(0));
        check("t1_drop", 64'(drop_count), 64'(0));
        check("t1_log_size", 64'(acc_log.size()), 64'(1));
        acc_log.delete();

        // 2: hysteresis -- held above threshold fires once; re-arm then fire again in step 6
        for (int s = 0; s < 5; s++) sweep(7, 5000, 0);
        sweep(7, -100, 0);
        sweep(7, 5000, 0);
        idle(4);
        check("t2_log_size", 64'(acc_log.size()), 64'(1));
        if (acc_log.size() > 0) check("t2_event", 64'(acc_log[0]), 64'({9'd7, 16'd6}));
        check("t2_step_count", 64'(step_count), 64'(7));
        sweep(-1, -100, -100);
        acc_log.delete();

        // 3: 20 fires with consumer stalled -> 16 queued, 4 dropped
        ev_ready = 1'b0;
        for (int i = 0; i < 20; i++) put(i, 5000);
        idle(4);
        check("t3_drop", 64'(drop_count), 64'(4));
        check("t3_head", 64'({ev_valid, ev_id, ev_step}), 64'({1'b1, 9'd0, 16'd8}));

        // 4: full FIFO, push coincides with pop -> accepted
        put(20, 5000);
        idle(1);
        ev_ready = 1'b1;
        idle(1);
        check("t4_drop", 64'(drop_count), 64'(4));
        idle(24);
        check("t4_log_size", 64'(acc_log.size()), 64'(17));
        if (acc_log.size() == 17) begin
            for (int k = 0; k < 16; k++) check("t4_order", 64'(acc_log[k].id), 64'(k));
            check("t4_last", 64'(acc_log[16].id), 64'(20));
        end

        // 5: step counting and out-of-range ids
        do_reset();
        repeat (1000) put(N - 1, 0);
        idle(1);
        check("t5_step_1000", 64'(step_count), 64'(1000));
        put(510, 5000);
        idle(3);
        check("t5_ignored_step", 64'(step_count), 64'(1000));
        check("t5_ignored_ev", 64'(ev_valid), 64'(0));

        // 6: reset with events queued
        ev_ready = 1'b0;
        for (int i = 1; i <= 5; i++) put(i, 5000);
        idle(3);
        check("t6_queued", 64'(ev_valid), 64'(1));
        do_reset();
        check("t6_rst_valid", 64'(ev_valid), 64'(0));
        check("t6_rst_counts", 64'({step_count, drop_count}), 64'(0));
        ev_ready = 1'b1;
        put(1, 5000);
        idle(2);
        check("t6_rearmed", 64'({ev_valid, ev_id}), 64'({1'b1, 9'd1}));
        idle(2);

`ifdef SPIKE_ENC_RATE_EN
        do_reset();
        put(N - 1, 0);
        put(N - 1, 0);
        put(3, 5000);
        put(4, 5000);
        put(5, 5000);
        put(N - 1, 0);
        idle(1);
        check("rate_step2", 64'(rate_count), 64'(3));
        check("rate_step_count", 64'(step_count), 64'(3));
        idle(4);
`endif

        // Randomized traffic; thresholds change only under reset
        for (int seg = 0; seg < 8; seg++) begin
            int hi;
            int gap;
            hi  = int'($urandom_range(0, 8000)) - 2000;
            gap = (seg == 3) ? 0 : int'($urandom_range(0, 3000));
            rst      = 1'b0;
            in_valid = 1'b0;
            thr_hi   = 16'(hi);
            thr_lo   = 16'(hi - gap);
            tick();
            rst = 1'b1;
            for (int c = 0; c < 2500; c++) begin
                int r;
                r = int'($urandom_range(0, 99));
                in_valid = (r < 80);
                if (r < 8)       in_id = ID_W'(N - 1);
                else if (r < 12) in_id = ID_W'($urandom_range(N, 511));
                else             in_id = ID_W'($urandom_range(0, 11));
                in_v     = 16'(int'($urandom_range(0, 16000)) - 6000);
                ev_ready = (int'($urandom_range(0, 99)) < (((seg % 2) == 1) ? 25 : 70));
                tick();
            end
            in_valid = 1'b0;
            ev_ready = 1'b1;
            repeat (40) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
